// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default width, FSM encoding
// and the bit-counter width helper.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A 1-bit operand still needs a 1-bit counter, so clamp $clog2 at 1.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        if (cw < 1) begin
            cw = 1;
        end else begin
            cw = cw;
        end
        return cw;
    endfunction

endpackage

// File: rtl/serial_adder_half_add.sv
// Single-bit half adder; two of these plus an OR form one full-adder bit-cell.
module half_add
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: accepts one operand pair, processes one bit per
// clock LSB first, and holds {carry_out,sum_out} until the result is taken.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_s0;
    logic w_c0;
    logic w_sum;
    logic w_c1;
    logic w_cout;
    logic w_last;

    half_add u_ha0 (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .sum   (w_s0),
        .carry (w_c0)
    );

    half_add u_ha1 (
        .a     (w_s0),
        .b     (r_carry),
        .sum   (w_sum),
        .carry (w_c1)
    );

    assign w_cout = w_c0 | w_c1;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Next-state logic for the IDLE/RUN/DONE handshake FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand shift registers, result shift register, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 is the LSB.
                    r_res   <= WIDTH'({w_sum, r_res} >> 1);
                    r_carry <= w_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end
                default: begin
                    r_res   <= r_res;
                    r_carry <= r_carry;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum_out   = r_res;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=8 instance for the main scenarios
// and a WIDTH=1 instance for the degenerate width.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_out;
    logic       carry_out;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] op_a1;
    logic [0:0] op_b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum_out1;
    logic       carry_out1;

    int n_tests;
    int n_fail;

    logic [8:0] sb[$];
    logic [1:0] sb1[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .op_a      (op_a1),
        .op_b      (op_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum_out   (sum_out1),
        .carry_out (carry_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one pair on the WIDTH=8 instance, check latency and result, then consume it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string name);
        int cyc;
        logic [8:0] exp;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
        end
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        sb.push_back({1'b0, a} + {1'b0, b});
        tick();
        in_valid = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL %s_latency: %0d cycles, required 8", name, cyc);
        end
        exp = sb.pop_front();
        n_tests++;
        if ({carry_out, sum_out} !== exp) begin
            n_fail++;
            $display("FAIL %s_result: carry=%b sum=%h, required carry=%b sum=%h",
                     name, carry_out, sum_out, exp[8], exp[7:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = 8'h00;
        op_b = 8'h00;
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        op_a1 = 1'b0;
        op_b1 = 1'b0;
        #12;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        n_tests++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_w1: in_ready=%b out_valid=%b, required 1/0", in_ready1, out_valid1);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_op(8'h00, 8'h00, "zero");
        run_op(8'hFF, 8'h01, "ripple");
        run_op(8'hA5, 8'h5A, "alt");
        run_op(8'hFF, 8'hFF, "max");
    endtask

    task automatic test_backpressure;
        int cyc;
        int bad;
        logic [8:0] exp;
        op_a = 8'h9C;
        op_b = 8'h77;
        in_valid = 1'b1;
        sb.push_back({1'b0, op_a} + {1'b0, op_b});
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        exp = sb.pop_front();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {carry_out, sum_out} !== exp) begin
                bad++;
                $display("FAIL backpressure_cycle%0d: out_valid=%b in_ready=%b carry=%b sum=%h, required 1/0 carry=%b sum=%h",
                         i, out_valid, in_ready, carry_out, sum_out, exp[8], exp[7:0]);
            end
            if (i == 5) begin
                in_valid = 1'b1;
                op_a = 8'hFF;
                op_b = 8'hFF;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_stable: %0d bad cycles, required 0", bad);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        op_a = 8'h55;
        op_b = 8'h0F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_running: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                seen++;
            end
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_result: out_valid seen %0d times, required 0", seen);
        end
        run_op(8'h03, 8'h04, "after_abort");
    endtask

    task automatic test_back_to_back;
        int n_acc;
        int n_res;
        int cyc;
        int t1;
        int t2;
        logic [8:0] exp;
        out_ready = 1'b1;
        op_a = 8'h3C;
        op_b = 8'h99;
        in_valid = 1'b1;
        n_acc = 0;
        n_res = 0;
        t1 = 0;
        t2 = 0;
        cyc = 0;
        while (n_res < 2 && cyc < 60) begin
            if (in_valid && in_ready) begin
                sb.push_back({1'b0, op_a} + {1'b0, op_b});
                n_acc++;
            end
            tick();
            cyc++;
            if (n_acc == 1) begin
                op_a = 8'h80;
                op_b = 8'h80;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                exp = sb.pop_front();
                n_tests++;
                if ({carry_out, sum_out} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: carry=%b sum=%h, required carry=%b sum=%h",
                             n_res, carry_out, sum_out, exp[8], exp[7:0]);
                end
                if (n_res == 0) begin
                    t1 = cyc;
                end else begin
                    t2 = cyc;
                end
                n_res++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (n_res !== 2 || (t2 - t1) !== 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d results, spacing %0d, required 2 results spaced 10", n_res, t2 - t1);
        end
        tick();
    endtask

    task automatic test_width1;
        int cyc;
        logic [1:0] exp;
        for (int k = 0; k < 4; k++) begin
            op_a1 = 1'(k >> 1);
            op_b1 = 1'(k);
            in_valid1 = 1'b1;
            sb1.push_back({1'b0, op_a1} + {1'b0, op_b1});
            tick();
            in_valid1 = 1'b0;
            op_a1 = ~op_a1;
            cyc = 0;
            while (out_valid1 !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            exp = sb1.pop_front();
            n_tests++;
            if (cyc !== 1 || {carry_out1, sum_out1} !== exp) begin
                n_fail++;
                $display("FAIL w1_case%0d: latency %0d carry=%b sum=%b, required latency 1 carry=%b sum=%b",
                         k, cyc, carry_out1, sum_out1, exp[1], exp[0]);
            end
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
